// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: sequencer state encoding and default counter widths.
package pulse_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_HIGH,
        S_GAP
    } pulse_seq_state_t;
    localparam int DEFAULT_CNT_WIDTH = 32;
    localparam int DEFAULT_REP_WIDTH = 8;
endpackage

// File: rtl/pulse_sequencer_if.sv
// pulse_sequencer_if: trigger/control inputs, timing configuration and status outputs of the sequencer.
interface pulse_sequencer_if
    import pulse_seq_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter int REP_WIDTH = DEFAULT_REP_WIDTH
);
    logic                 trigger;
    logic                 arm;
    logic                 abort;
    logic [CNT_WIDTH-1:0] delay_cycles;
    logic [CNT_WIDTH-1:0] width_cycles;
    logic [CNT_WIDTH-1:0] gap_cycles;
    logic [REP_WIDTH-1:0] repeat_count;
    logic                 pulse_out;
    logic                 armed;
    logic                 busy;
    logic                 done;
    logic                 trigger_missed;
    modport master (
        output trigger, arm, abort, delay_cycles, width_cycles, gap_cycles, repeat_count,
        input  pulse_out, armed, busy, done, trigger_missed
    );
    modport slave (
        input  trigger, arm, abort, delay_cycles, width_cycles, gap_cycles, repeat_count,
        output pulse_out, armed, busy, done, trigger_missed
    );
endinterface

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down-counter that stops at zero, with a registered terminal-count flag.
module load_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic             tc
);
    logic [WIDTH-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b1;
        end else if (load) begin
            count <= value;
            tc    <= value == '0;
        end else if (en && count != '0) begin
            count <= count - WIDTH'(1);
            tc    <= count == WIDTH'(1);
        end
    end
endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: one-shot armed trigger to programmable delay/width/gap/repeat pulse train.
// Outputs are registered decodes of the current state, so every output trails the state by one edge.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter int REP_WIDTH = DEFAULT_REP_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    pulse_sequencer_if.slave  bus
);
    pulse_seq_state_t     state, next_state;
    logic [CNT_WIDTH-1:0] width_sh, gap_sh, phase_value;
    logic [REP_WIDTH-1:0] rep_value;
    logic                 phase_load, phase_en, phase_tc;
    logic                 rep_load, rep_en, rep_tc;
    logic                 start, busy_state, finish;

    // A phase of n cycles loads n-1; zero-length phases are stretched to one cycle.
    function automatic logic [CNT_WIDTH-1:0] len_m1(input logic [CNT_WIDTH-1:0] n);
        return (n == '0) ? '0 : n - CNT_WIDTH'(1);
    endfunction

    assign start      = state == S_ARMED && bus.trigger && !bus.abort;
    assign busy_state = state == S_DELAY || state == S_HIGH || state == S_GAP;
    assign rep_value  = (bus.repeat_count == '0) ? '0 : bus.repeat_count - REP_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        phase_load  = 1'b0;
        phase_en    = 1'b0;
        phase_value = len_m1(width_sh);
        rep_load    = 1'b0;
        rep_en      = 1'b0;
        if (bus.abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: next_state = bus.arm ? S_ARMED : S_IDLE;
                S_ARMED: begin
                    if (bus.trigger) begin
                        phase_load  = 1'b1;
                        rep_load    = 1'b1;
                        next_state  = (bus.delay_cycles == '0) ? S_HIGH : S_DELAY;
                        phase_value = (bus.delay_cycles == '0) ? len_m1(bus.width_cycles)
                                                               : len_m1(bus.delay_cycles);
                    end
                end
                S_DELAY: begin
                    next_state = phase_tc ? S_HIGH : S_DELAY;
                    phase_load = phase_tc;
                    phase_en   = !phase_tc;
                end
                S_HIGH: begin
                    next_state  = !phase_tc ? S_HIGH : (rep_tc ? S_IDLE : S_GAP);
                    phase_load  = phase_tc && !rep_tc;
                    phase_en    = !phase_tc;
                    phase_value = len_m1(gap_sh);
                end
                S_GAP: begin
                    next_state = phase_tc ? S_HIGH : S_GAP;
                    phase_load = phase_tc;
                    phase_en   = !phase_tc;
                    rep_en     = phase_tc;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    load_down_counter #(.WIDTH(CNT_WIDTH)) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (phase_load),
        .en    (phase_en),
        .value (phase_value),
        .tc    (phase_tc)
    );

    load_down_counter #(.WIDTH(REP_WIDTH)) u_rep_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (rep_load),
        .en    (rep_en),
        .value (rep_value),
        .tc    (rep_tc)
    );

    // Delay and repeat are captured directly by the counters at the trigger edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_sh <= '0;
            gap_sh   <= '0;
        end else if (start) begin
            width_sh <= bus.width_cycles;
            gap_sh   <= bus.gap_cycles;
        end
    end

    // finish marks the last HIGH edge; done follows it so it coincides with the pulse fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish             <= 1'b0;
            bus.pulse_out      <= 1'b0;
            bus.armed          <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.trigger_missed <= 1'b0;
        end else begin
            finish             <= state == S_HIGH && phase_tc && rep_tc && !bus.abort;
            bus.pulse_out      <= state == S_HIGH && !bus.abort;
            bus.armed          <= state == S_ARMED && !bus.abort;
            bus.busy           <= busy_state && !bus.abort;
            bus.done           <= finish;
            bus.trigger_missed <= (state == S_IDLE && bus.arm && !bus.abort) ? 1'b0
                                  : bus.trigger_missed | (busy_state && bus.trigger);
        end
    end
endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: randomized and directed checks against an arithmetic model of the pulse train.
module tb_pulse_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pulse_sequencer_if #(.CNT_WIDTH(32), .REP_WIDTH(8)) bus ();

    pulse_sequencer #(.CNT_WIDTH(32), .REP_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_block();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        tick();
        n_checks++;
        if (bus.armed !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_armed: got %b expected 1", bus.armed);
        end
    endtask

    // Trigger at edge k; t counts edges after k. Pulse i is high for t in
    // [D+1+i*(W+G), D+1+i*(W+G)+W); done and busy fall at the end of the last pulse.
    task automatic run_seq(input int d, input int w, input int g, input int r,
                           input int miss_t, input int chg_t);
        int   we, ge, re, fin, u;
        logic ep, ed, eb;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        re = (r == 0) ? 1 : r;
        fin = d + 1 + (re - 1) * (we + ge) + we;
        bus.delay_cycles = 32'(d);
        bus.width_cycles = 32'(w);
        bus.gap_cycles   = 32'(g);
        bus.repeat_count = 8'(r);
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        for (int t = 0; t <= fin + 2; t++) begin
            u  = t - d - 1;
            ep = (u >= 0) && ((u / (we + ge)) < re) && ((u % (we + ge)) < we);
            ed = t == fin;
            eb = t >= 1 && t < fin;
            n_checks += 3;
            if (bus.pulse_out !== ep) begin
                n_fail++;
                $display("FAIL seq_pulse d=%0d w=%0d g=%0d r=%0d t=%0d: got %b expected %b", d, w, g, r, t, bus.pulse_out, ep);
            end
            if (bus.done !== ed) begin
                n_fail++;
                $display("FAIL seq_done d=%0d w=%0d g=%0d r=%0d t=%0d: got %b expected %b", d, w, g, r, t, bus.done, ed);
            end
            if (bus.busy !== eb) begin
                n_fail++;
                $display("FAIL seq_busy d=%0d w=%0d g=%0d r=%0d t=%0d: got %b expected %b", d, w, g, r, t, bus.busy, eb);
            end
            if (t == miss_t) bus.trigger = 1'b1;
            if (t == chg_t) bus.width_cycles = 32'd9;
            tick();
            bus.trigger = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.trigger = 1'b0;
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        bus.delay_cycles = '0;
        bus.width_cycles = '0;
        bus.gap_cycles = '0;
        bus.repeat_count = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({bus.pulse_out, bus.armed, bus.busy, bus.done, bus.trigger_missed} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bus.pulse_out, bus.armed, bus.busy, bus.done, bus.trigger_missed});
        end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_not_armed();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({bus.pulse_out, bus.busy, bus.armed, bus.trigger_missed} !== 4'b0) begin
                n_fail++;
                $display("FAIL idle_trigger cyc=%0d: got %b expected 0000", i,
                         {bus.pulse_out, bus.busy, bus.armed, bus.trigger_missed});
            end
            tick();
        end
    endtask

    task automatic test_directed();
        arm_block();
        run_seq(3, 2, 4, 3, -1, -1);
        arm_block();
        run_seq(0, 0, 0, 0, -1, -1);
    endtask

    task automatic test_missed();
        arm_block();
        run_seq(2, 3, 2, 2, 3, -1);
        n_checks++;
        if (bus.trigger_missed !== 1'b1) begin
            n_fail++;
            $display("FAIL missed_set: got %b expected 1", bus.trigger_missed);
        end
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        n_checks++;
        if (bus.trigger_missed !== 1'b0) begin
            n_fail++;
            $display("FAIL missed_clear: got %b expected 0", bus.trigger_missed);
        end
        tick();
    endtask

    task automatic test_abort();
        arm_block();
        bus.delay_cycles = 32'd1;
        bus.width_cycles = 32'd2;
        bus.gap_cycles = 32'd3;
        bus.repeat_count = 8'd3;
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bus.pulse_out !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_first_pulse: got %b expected 1", bus.pulse_out);
        end
        repeat (2) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b expected 000", {bus.pulse_out, bus.busy, bus.done});
        end
        // An unarmed trigger after abort must not start anything: the block is back in IDLE.
        bus.trigger = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            bus.trigger = 1'b0;
            n_checks++;
            if ({bus.pulse_out, bus.done, bus.armed, bus.busy} !== 4'b0) begin
                n_fail++;
                $display("FAIL abort_idle cyc=%0d: got %b expected 0000", i,
                         {bus.pulse_out, bus.done, bus.armed, bus.busy});
            end
        end
        arm_block();
        bus.trigger = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.trigger = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({bus.pulse_out, bus.busy, bus.armed, bus.done} !== 4'b0) begin
                n_fail++;
                $display("FAIL trig_abort cyc=%0d: got %b expected 0000", i,
                         {bus.pulse_out, bus.busy, bus.armed, bus.done});
            end
            tick();
        end
    endtask

    task automatic test_shadow();
        arm_block();
        run_seq(4, 2, 1, 2, -1, 1);
        arm_block();
        run_seq(4, 9, 1, 2, -1, -1);
    endtask

    task automatic test_reset_mid();
        arm_block();
        bus.delay_cycles = 32'd1;
        bus.width_cycles = 32'd5;
        bus.gap_cycles = 32'd1;
        bus.repeat_count = 8'd1;
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.pulse_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_high: got %b expected 1", bus.pulse_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.pulse_out, bus.busy} !== 2'b0) begin
            n_fail++;
            $display("FAIL rst_async_clear: got %b expected 00", {bus.pulse_out, bus.busy});
        end
        #3 rst_n = 1'b1;
        bus.trigger = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.trigger = 1'b0;
            n_checks++;
            if ({bus.pulse_out, bus.armed, bus.busy} !== 3'b0) begin
                n_fail++;
                $display("FAIL rst_stays_idle cyc=%0d: got %b expected 000", i,
                         {bus.pulse_out, bus.armed, bus.busy});
            end
        end
        arm_block();
        run_seq(1, 1, 1, 1, -1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            arm_block();
            run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_not_armed();
        test_directed();
        test_missed();
        test_abort();
        test_shadow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Consumes the single-cycle, debounced rising-edge pulse produced by the button trigger stage and turns it into a programmable output pulse train. The train has a start delay, a pulse width, an inter-pulse gap and a repeat count. It sits between the front-panel/trigger conditioning and the output pin driver, so a button press or external edge fires a precisely timed sequence. One-shot arming prevents re-fires until software or a switch re-arms it.

## Interface
- `CNT_WIDTH`, 32: width of the delay/width/gap counters.
- `REP_WIDTH`, 8: width of the repeat counter.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  single-cycle trigger pulse from the upstream edge stage.
- `arm`  in  1  level; a high sample in IDLE moves the block to ARMED.
- `abort`  in  1  level; a high sample forces return to IDLE.
- `delay_cycles`  in  CNT_WIDTH  cycles from trigger to the first pulse rise.
- `width_cycles`  in  CNT_WIDTH  high time per pulse; 0 is treated as 1.
- `gap_cycles`  in  CNT_WIDTH  low time between pulses; 0 is treated as 1.
- `repeat_count`  in  REP_WIDTH  number of pulses; 0 is treated as 1.
- `pulse_out`  out  1  registered output pulse train.
- `armed`  out  1  high while in ARMED.
- `busy`  out  1  high in DELAY, HIGH and GAP.
- `done`  out  1  one-cycle strobe when the sequence completes.
- `trigger_missed`  out  1  sticky; set by a trigger seen while busy, cleared on entry to ARMED.

## Operation
- States: IDLE, ARMED, DELAY, HIGH, GAP.
- IDLE -> ARMED when `arm` is sampled high.
- ARMED -> DELAY when `trigger` is sampled high.
  - On that edge, `delay_cycles`, `width_cycles`, `gap_cycles` and `repeat_count` are latched into shadow registers.
  - Input changes after that edge have no effect on the running sequence.
- DELAY counts the latched delay down, then goes to HIGH.
  - If the latched delay is 0, the block goes directly to HIGH on the trigger edge.
- HIGH holds for the width count, then:
  - goes to GAP if pulses remain;
  - otherwise goes to IDLE and strobes `done`.
- GAP holds for the gap count, then returns to HIGH and decrements the remaining-pulse count.
- The block is one-shot: after completion it sits in IDLE and needs `arm` again. `arm` held high re-arms on the next cycle.
- `abort` has priority over every other input in every state.
  - Next state is IDLE; `pulse_out` is low on the following edge.
  - No `done` strobe is issued.
- A trigger in DELAY, HIGH or GAP is ignored for sequencing and sets `trigger_missed`.
- A trigger in IDLE is ignored silently.
- `trigger` and `abort` sampled high on the same edge in ARMED: abort wins and the block goes to IDLE.
- Counters are unsigned, CNT_WIDTH wide and never wrap. The maximum value gives exactly 2^CNT_WIDTH−1 cycles.

## Timing
- Reset values: state IDLE; `pulse_out`, `armed`, `busy`, `done` and `trigger_missed` all 0; shadow registers 0.
- All outputs are registered, with no combinational input-to-output paths.
- Take the trigger sampled high at edge k with delay D, width W and gap G:
  - `pulse_out` rises at edge k+D+1;
  - it stays high for exactly W cycles;
  - it stays low for exactly G cycles between pulses.
- `done` is high for the single cycle starting at the falling edge of the last pulse; `busy` falls on that same edge.
- `armed` rises one edge after `arm` is sampled.
- The block can be re-armed and re-triggered back-to-back with no dead cycle beyond the arm sampling edge.
- Reset assertion mid-sequence clears all outputs immediately (asynchronously).
- Reset deassertion is synchronized externally; the block needs no internal synchronizer.

## Structure
- `pulse_seq_pkg`: the state enum `pulse_seq_state_t` and the constants `DEFAULT_CNT_WIDTH` and `DEFAULT_REP_WIDTH`.
- Sub-module `load_down_counter`: parameterized width, with load, decrement enable and a registered terminal-count flag. It is instantiated once for delay/width/gap (reloaded per phase) and once for repeats.
- The top level holds the FSM, shadow registers and output registers.

## Test plan
- Reset, arm, then trigger with D=3, W=2, G=4, R=3 -> `pulse_out` rises at k+4, high 2 / low 4 ×3, `done` one cycle at the last fall, `busy` then 0.
- D=0, W=0, R=0 -> a single 1-cycle pulse at k+1, then `done`.
- Trigger while not armed -> no pulse, `trigger_missed` stays 0. Second trigger during HIGH -> sequence unchanged, `trigger_missed`=1 until the next arm.
- `abort` in GAP after pulse 1 of 3 -> `pulse_out` 0, state IDLE, no `done`. Same-edge `trigger` and `abort` in ARMED -> no pulse.
- Change `width_cycles` from 2 to 9 during DELAY -> pulses keep W=2. Re-arm and re-trigger -> W=9.
- Assert `rst_n` low mid-HIGH -> `pulse_out`=0 without waiting for a clock edge. After release, the block stays in IDLE until armed.
